// File: rtl/m_clk_pkg.sv
// Shared types and helpers for the programmable clock divider.
package m_clk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  localparam int unsigned MIN_DIV = 2;

  // Ratios below MIN_DIV cannot produce a two-phase waveform, so they are raised to it.
  function automatic logic [31:0] clamp_div(input logic [31:0] ratio);
    return (ratio < MIN_DIV) ? MIN_DIV : ratio;
  endfunction

endpackage

// File: rtl/m_clk_div_neg.sv
// Falling-edge phase flop for odd divide ratios, clocked through the inverter cell.
module m_clk_div_neg (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic clk_n;

  m_inv u_inv (
    .a (clk),
    .y (clk_n)
  );

  // Retime the rising-edge phase by half a source period; rst is resampled on this edge.
  always_ff @(posedge clk_n) begin
    if (rst) q <= 1'b0;
    else     q <= d;
  end

endmodule

// File: rtl/m_inv.sv
// Clock-tree inverter cell wrapper; swap the body for a library cell when mapping.
module m_inv (
  input  logic a,
  output logic y
);

  assign y = ~a;

endmodule

// File: rtl/m_clk_div.sv
// Glitch-free programmable clock divider with 50% duty for even and odd ratios,
// period-aligned ratio reprogramming and clean start/stop.
module m_clk_div
  import m_clk_pkg::*;
#(
  parameter int unsigned DIV_W   = 8,
  parameter int unsigned RST_DIV = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] div_ratio,
  input  logic             div_ld,
  output logic             div_ack,
  output logic [DIV_W-1:0] cur_ratio,
  output logic             running,
  output logic             clk_out
);

  state_t           state;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] active;
  logic [DIV_W-1:0] pending;
  logic             pending_vld;
  logic             pos_q;
  logic             neg_q;
  logic [DIV_W-1:0] half;
  logic             boundary;
  logic             apply;

  // Last cycle of an output period; pos_q is already low here for every N >= 3.
  assign boundary = (cnt == active - 1'b1);
  // N/2 for even N and (N-1)/2 for odd N are the same shift.
  assign half     = active >> 1;
  // A pending ratio lands at a period boundary, or straight away when stopped.
  assign apply    = pending_vld && ((state == IDLE) || boundary);

  // Counter, FSM, ratio shadow and rising-edge phase.
  // NOTE: every register here uses <= so all of them see the pre-edge values;
  // pos_q must be computed from the old cnt and the old half at a ratio change.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      active      <= DIV_W'(RST_DIV);
      pending     <= DIV_W'(RST_DIV);
      pending_vld <= 1'b0;
      pos_q       <= 1'b0;
      div_ack     <= 1'b0;
    end else begin
      div_ack <= apply;

      // A load in the applying cycle refills the shadow for the next boundary.
      if (div_ld) begin
        pending     <= DIV_W'(clamp_div(32'(div_ratio)));
        pending_vld <= 1'b1;
      end else if (apply) begin
        pending_vld <= 1'b0;
      end

      if (apply) active <= pending;

      case (state)
        IDLE: begin
          cnt   <= '0;
          pos_q <= 1'b0;
          if (en) state <= RUN;
        end
        RUN, STOP: begin
          pos_q <= (cnt < half);
          cnt   <= boundary ? '0 : cnt + 1'b1;
          if (en)                 state <= RUN;
          else if (state == RUN)  state <= STOP;
          else if (boundary)      state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Half-period extension, only meaningful for odd ratios.
  m_clk_div_neg u_neg (
    .clk (clk),
    .rst (rst),
    .d   (pos_q & active[0]),
    .q   (neg_q)
  );

  assign running   = (state != IDLE);
  assign cur_ratio = active;
  // Gating neg_q with running drops the output on the same rising edge that
  // samples rst, instead of waiting for the falling-edge flop to clear.
  assign clk_out   = pos_q | (neg_q & running);

endmodule

// File: tb/tb_m_clk_div.sv
// Self-checking bench for m_clk_div: a half-cycle monitor compares every output
// segment against widths queued when each scenario is started.
module tb_m_clk_div;

  localparam int unsigned DIV_W   = 8;
  localparam int unsigned RST_DIV = 2;

  typedef struct {
    logic lvl;
    int   width;   // in half clk periods; negative means any width
  } seg_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [DIV_W-1:0] div_ratio;
  logic             div_ld;
  logic             div_ack;
  logic [DIV_W-1:0] cur_ratio;
  logic             running;
  logic             clk_out;

  int   n_checks = 0;
  int   n_fail   = 0;
  seg_t exp_q[$];

  m_clk_div #(
    .DIV_W   (DIV_W),
    .RST_DIV (RST_DIV)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .div_ratio (div_ratio),
    .div_ld    (div_ld),
    .div_ack   (div_ack),
    .cur_ratio (cur_ratio),
    .running   (running),
    .clk_out   (clk_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Output segment monitor: one sample per half period, just after each edge.
  logic mon_lvl = 1'b0;
  int   mon_run = 0;
  always @(clk) begin : mon
    seg_t e;
    #1;
    if (clk_out !== mon_lvl) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("seg_level", 32'(mon_lvl), 32'(e.lvl));
        if (e.width >= 0) check("seg_width", 32'(mon_run), 32'(e.width));
      end
      mon_lvl = clk_out;
      mon_run = 1;
    end else begin
      mon_run++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_seg(input logic lvl, input int width);
    seg_t s;
    s.lvl   = lvl;
    s.width = width;
    exp_q.push_back(s);
  endtask

  task automatic push_pairs(input int hi, input int lo, input int n);
    for (int i = 0; i < n; i++) begin
      push_seg(1'b1, hi);
      push_seg(1'b0, lo);
    end
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      tick(1);
      k++;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic stop_and_settle();
    int k;
    en = 1'b0;
    k  = 0;
    while (running !== 1'b0 && k < 40) begin
      tick(1);
      k++;
    end
    check("idle_reached", 32'(running), 32'd0);
    tick(2);
  endtask

  // Load a ratio while idle; it must be acknowledged the cycle after capture.
  task automatic load_ratio(input logic [DIV_W-1:0] r, input int exp_ratio);
    div_ratio = r;
    div_ld    = 1'b1;
    tick(1);
    div_ld = 1'b0;
    check("ld_ack_early", 32'(div_ack), 32'd0);
    tick(1);
    check("ld_ack", 32'(div_ack), 32'd1);
    check("ld_cur_ratio", 32'(cur_ratio), 32'(exp_ratio));
    tick(1);
    check("ld_ack_once", 32'(div_ack), 32'd0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; div_ld = 1'b0; div_ratio = '0;
    tick(4);
    check("rst_clk_out", 32'(clk_out), 32'd0);
    check("rst_running", 32'(running), 32'd0);
    check("rst_cur_ratio", 32'(cur_ratio), 32'(RST_DIV));
    check("rst_ack", 32'(div_ack), 32'd0);
    rst = 1'b0;
    tick(1);

    // Even ratio 4: two cycles high, two low, first rise one cycle after en.
    load_ratio(8'd4, 4);
    push_seg(1'b0, -1);
    push_pairs(4, 4, 2);
    en = 1'b1;
    tick(1);
    check("first_rise_early", 32'(clk_out), 32'd0);
    check("run_running", 32'(running), 32'd1);
    tick(1);
    check("first_rise", 32'(clk_out), 32'd1);
    wait_drain("drain_even4", 40);
    stop_and_settle();

    // Odd ratios: 1.5 / 1.5 and 2.5 / 2.5 clk periods.
    load_ratio(8'd3, 3);
    push_seg(1'b0, -1);
    push_pairs(3, 3, 3);
    en = 1'b1;
    wait_drain("drain_odd3", 40);
    stop_and_settle();

    load_ratio(8'd5, 5);
    push_seg(1'b0, -1);
    push_pairs(5, 5, 3);
    en = 1'b1;
    wait_drain("drain_odd5", 60);
    stop_and_settle();

    // Live change 6 -> 10 loaded at cnt=2: the current period completes first.
    load_ratio(8'd6, 6);
    push_seg(1'b0, -1);
    push_pairs(6, 6, 1);
    push_pairs(10, 10, 1);
    push_seg(1'b1, 10);
    en = 1'b1;
    tick(3);
    div_ratio = 8'd10;
    div_ld    = 1'b1;
    tick(1);
    div_ld = 1'b0;
    tick(2);
    check("live_ack_early", 32'(div_ack), 32'd0);
    check("live_old_ratio", 32'(cur_ratio), 32'd6);
    tick(1);
    check("live_ack", 32'(div_ack), 32'd1);
    check("live_new_ratio", 32'(cur_ratio), 32'd10);
    tick(1);
    check("live_ack_once", 32'(div_ack), 32'd0);
    wait_drain("drain_live", 80);
    stop_and_settle();

    // Stop at cnt=1 with N=4: period finishes, then output stays low.
    load_ratio(8'd4, 4);
    push_seg(1'b0, -1);
    push_seg(1'b1, 4);
    en = 1'b1;
    tick(2);
    en = 1'b0;
    tick(1);
    check("stop_running_cnt2", 32'(running), 32'd1);
    tick(1);
    check("stop_running_cnt3", 32'(running), 32'd1);
    tick(1);
    check("stop_running_idle", 32'(running), 32'd0);
    for (int i = 0; i < 3; i++) begin
      check("stop_clk_low", 32'(clk_out), 32'd0);
      tick(1);
    end
    wait_drain("drain_stop", 10);

    // Re-raise en while in STOP: no gap and no short pulse.
    push_seg(1'b0, -1);
    push_pairs(4, 4, 3);
    en = 1'b1;
    tick(2);
    en = 1'b0;
    tick(1);
    check("restart_stop_running", 32'(running), 32'd1);
    en = 1'b1;
    tick(1);
    check("restart_running", 32'(running), 32'd1);
    tick(4);
    check("restart_running_later", 32'(running), 32'd1);
    wait_drain("drain_restart", 40);
    stop_and_settle();

    // Ratio 0 clamps to 2: output toggles every cycle.
    load_ratio(8'd0, 2);
    push_seg(1'b0, -1);
    push_pairs(2, 2, 3);
    en = 1'b1;
    wait_drain("drain_clamp", 30);
    stop_and_settle();

    // Load on the boundary cycle itself: applied one period later.
    load_ratio(8'd4, 4);
    push_seg(1'b0, -1);
    push_pairs(4, 4, 2);
    push_pairs(6, 6, 1);
    en = 1'b1;
    tick(4);
    div_ratio = 8'd6;
    div_ld    = 1'b1;
    tick(1);
    div_ld = 1'b0;
    check("bnd_ack_early", 32'(div_ack), 32'd0);
    check("bnd_old_ratio", 32'(cur_ratio), 32'd4);
    tick(3);
    check("bnd_still_old", 32'(cur_ratio), 32'd4);
    tick(1);
    check("bnd_ack", 32'(div_ack), 32'd1);
    check("bnd_new_ratio", 32'(cur_ratio), 32'd6);
    wait_drain("drain_bnd", 60);
    stop_and_settle();

    // Reset at cnt=3 with N=7: high phase cut at 3 cycles, then a clean restart at RST_DIV.
    load_ratio(8'd7, 7);
    push_seg(1'b0, -1);
    push_pairs(6, 6, 1);
    push_pairs(2, 2, 1);
    push_seg(1'b1, 2);
    en = 1'b1;
    tick(4);
    check("rstmid_high_before", 32'(clk_out), 32'd1);
    rst = 1'b1;
    tick(1);
    check("rstmid_clk_out", 32'(clk_out), 32'd0);
    check("rstmid_running", 32'(running), 32'd0);
    check("rstmid_cur_ratio", 32'(cur_ratio), 32'(RST_DIV));
    @(negedge clk);
    #1;
    check("rstmid_clk_out_neg", 32'(clk_out), 32'd0);
    tick(1);
    rst = 1'b0;
    tick(1);
    check("rstrel_running", 32'(running), 32'd1);
    check("rstrel_clk_low", 32'(clk_out), 32'd0);
    tick(1);
    check("rstrel_first_rise", 32'(clk_out), 32'd1);
    wait_drain("drain_rst", 30);
    stop_and_settle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/m_clk_div.md
Name: m_clk_div

Overview:
- Parametrised, glitch-free programmable clock divider for the std_cells library.
- Successor to the single-cell clock-tree primitives: it produces a divided clock with 50% duty for both even and odd ratios.
- The divide ratio can be reprogrammed on the fly, with the change taking effect only at an output-period boundary.
- A clean start/stop enable is provided.
- The negative-edge phase flop is clocked through an m_inv instance, so the clock-tree inverter is technology-mapped like the other cell wrappers.

Parameters:
- DIV_W, 8, width of the ratio field (ratios 2..2^DIV_W-1).
- RST_DIV, 2, active ratio after reset; must be >= 2.

Ports:
- clk  in  1  source clock.
- rst  in  1  synchronous, active-high reset, sampled on rising clk.
- en  in  1  run request; level-sensitive.
- div_ratio  in  DIV_W  requested ratio N; values 0 and 1 are clamped to 2.
- div_ld  in  1  one-cycle strobe; captures div_ratio into the pending register.
- div_ack  out  1  one-cycle pulse in the cycle a pending ratio becomes active.
- cur_ratio  out  DIV_W  currently active ratio (post-clamp).
- running  out  1  high while the divider is producing output periods.
- clk_out  out  1  divided clock.

Behaviour:
Reset (synchronous):
- cnt=0, active=RST_DIV, pending_vld=0, state=IDLE.
- pos_q=0, div_ack=0, running=0.
- neg_q is cleared on the first falling clk edge while rst is high.
- clk_out=0 throughout reset.
- Reset mid-period aborts the period immediately: clk_out is low from the rising edge where rst is sampled high.

Counter and waveform (active ratio N):
- cnt counts 0..N-1 and wraps to 0.
- Even N: pos_q = (cnt < N/2); clk_out = pos_q. Result: N/2 cycles high, N/2 cycles low.
- Odd N: pos_q = (cnt < (N-1)/2); neg_q = pos_q resampled on the falling edge of clk (via m_inv); clk_out = pos_q | neg_q. Result: high for N/2 clk periods exactly, e.g. 1.5 of 3.
- neg_q is forced to 0 when N is even.
- Period boundary: cycle with cnt==N-1.

Ratio update:
- div_ld registers clamp(div_ratio) into pending and sets pending_vld. A newer div_ld overwrites pending.
- At a boundary with pending_vld=1: active<=pending, cnt<=0, pending_vld<=0, div_ack pulses on the next cycle.
- div_ld asserted in the boundary cycle itself is applied at the following boundary, not the current one.
- In IDLE, a pending ratio is applied the cycle after capture, with div_ack pulsed.

FSM:
- IDLE: cnt=0, clk_out=0. en=1 -> RUN next cycle with cnt=0; first clk_out rising edge is 1 cycle after en is sampled.
- RUN: en=0 -> STOP.
- STOP: continue counting to the boundary; at the boundary -> IDLE. If en returns before the boundary -> RUN with no glitch.
- running = (state != IDLE).

Guarantees:
- No high or low output pulse shorter than floor(N/2) clk periods, including across ratio change, stop, and reset release.

Decomposition:
- Package m_clk_pkg holds:
  - state enum {IDLE, RUN, STOP};
  - localparam MIN_DIV=2;
  - a clamp function clamp_div(ratio) returning max(ratio, MIN_DIV).
- One sub-module, m_clk_div_neg: the negedge phase flop.
  - Instantiates m_inv on clk to derive its clock.
  - Has its own rst resample.
  - Keeps the inverter mapping technology-selectable.
- Counter, FSM and ratio shadowing stay in m_clk_div.

Test Plan:
- Even ratio: rst 4 cycles, div_ratio=4, div_ld, en=1 -> div_ack pulse, cur_ratio=4; clk_out 2 high / 2 low; first rise 1 cycle after en.
- Odd duty: N=3 -> clk_out high 1.5 clk periods, low 1.5, period 3. N=5 -> high 2.5 / low 2.5. Check with a negedge-aware checker.
- Live change: running at N=6, div_ld with 10 at cnt=2 -> old period completes (6 cycles), div_ack at boundary+1, following periods are 10 cycles; no pulse shorter than 3.
- Stop and restart: N=4, drop en at cnt=1 -> period finishes, running falls at boundary, clk_out stays 0. Re-raise en during STOP -> no gap, no short pulse.
- Clamp and boundary load: div_ratio=0 loaded -> cur_ratio=2, toggle every cycle. div_ld exactly on boundary cycle -> applied one period later.
- Reset mid-period: N=7, assert rst at cnt=3 -> clk_out low on that edge, cur_ratio=RST_DIV, running=0. After release with en=1 -> clean restart from cnt=0.
